// File: rtl/thirty_two_bit_divider.sv
// Multicycle signed integer divider (restoring shift-subtract).
//
// A start pulse in IDLE or DONE samples the operands. SETUP either resolves
// the two exception cases at once (divide-by-zero, MIN/-1 overflow) or loads
// the operand magnitudes. RUN then performs WIDTH restoring iterations, and
// FIX applies the result sign. DONE raises result_rdy for one cycle.
// Quotient truncates toward zero.
//
// Optional build macro: REMAINDER_OUT_EN adds a remainder output whose sign
// follows the dividend.
//
// Ports:
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   start      one-cycle request; operands sampled on the same edge
//   dividend   signed numerator
//   divisor    signed denominator
//   quotient   signed result, held until the next result
//   exception  divide-by-zero or overflow, held with quotient
//   result_rdy one-cycle pulse when quotient/exception are valid
//   remainder  (REMAINDER_OUT_EN only) signed remainder, sign of dividend
//   busy       high from accepted start through the result_rdy cycle
module thirty_two_bit_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic             exception,
    output logic             result_rdy,
`ifdef REMAINDER_OUT_EN
    output logic [WIDTH-1:0] remainder,
`endif
    output logic             busy
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StRun,
        StFix,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] dvnd_q, dvnd_d;
    // Holds the raw divisor until SETUP, then its magnitude during RUN.
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic             exception_q, exception_d;
`ifdef REMAINDER_OUT_EN
    logic [WIDTH-1:0] remainder_q, remainder_d;
`endif

    // Partial remainder after the shift, and the trial subtraction result.
    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] rem_diff;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            dvnd_q      <= '0;
            dvsr_q      <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            quotient_q  <= '0;
            exception_q <= 1'b0;
`ifdef REMAINDER_OUT_EN
            remainder_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvnd_q      <= dvnd_d;
            dvsr_q      <= dvsr_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            quotient_q  <= quotient_d;
            exception_q <= exception_d;
`ifdef REMAINDER_OUT_EN
            remainder_q <= remainder_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvnd_d      = dvnd_q;
        dvsr_d      = dvsr_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        quotient_d  = quotient_q;
        exception_d = exception_q;
`ifdef REMAINDER_OUT_EN
        remainder_d = remainder_q;
`endif
        rem_shift   = {rem_q, quo_q[WIDTH-1]};
        rem_diff    = rem_shift - {1'b0, dvsr_q};
        result_rdy  = (state_q == StDone);
        busy        = (state_q != StIdle);

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    dvnd_d   = dividend;
                    dvsr_d   = divisor;
                    sign_a_d = dividend[WIDTH-1];
                    sign_b_d = divisor[WIDTH-1];
                    state_d  = StSetup;
                end else if (state_q == StDone) begin
                    state_d = StIdle;
                end
            end

            StSetup: begin
                if (dvsr_q == '0) begin
                    quotient_d  = '0;
                    exception_d = 1'b1;
`ifdef REMAINDER_OUT_EN
                    remainder_d = '0;
`endif
                    state_d     = StDone;
                end else if (dvnd_q == MinNeg && dvsr_q == '1) begin
                    // MIN / -1 is not representable; report MIN with the flag.
                    quotient_d  = MinNeg;
                    exception_d = 1'b1;
`ifdef REMAINDER_OUT_EN
                    remainder_d = '0;
`endif
                    state_d     = StDone;
                end else begin
                    // Magnitude of MIN is 2^(WIDTH-1), which still fits unsigned.
                    quo_d   = sign_a_q ? (~dvnd_q + 1'b1) : dvnd_q;
                    dvsr_d  = sign_b_q ? (~dvsr_q + 1'b1) : dvsr_q;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end

            StRun: begin
                // A clear borrow bit means the shifted remainder >= |divisor|.
                if (!rem_diff[WIDTH]) begin
                    rem_d = rem_diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastIter) begin
                    state_d = StFix;
                end
            end

            StFix: begin
                quotient_d  = (sign_a_q ^ sign_b_q) ? (~quo_q + 1'b1) : quo_q;
                exception_d = 1'b0;
`ifdef REMAINDER_OUT_EN
                remainder_d = sign_a_q ? (~rem_q + 1'b1) : rem_q;
`endif
                state_d     = StDone;
            end

            default: state_d = StIdle;
        endcase
    end

    assign quotient  = quotient_q;
    assign exception = exception_q;
`ifdef REMAINDER_OUT_EN
    assign remainder = remainder_q;
`endif

endmodule

// File: tb/tb_thirty_two_bit_divider.sv
module tb_thirty_two_bit_divider;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] quotient;
    logic        exception;
    logic        result_rdy;
    logic        busy;
`ifdef REMAINDER_OUT_EN
    logic [31:0] remainder;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int t_start = 0;
    logic chk_en = 1'b0;

    thirty_two_bit_divider #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .exception (exception),
        .result_rdy(result_rdy),
`ifdef REMAINDER_OUT_EN
        .remainder (remainder),
`endif
        .busy      (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: plain signed division with the two special cases.
    function automatic void calc(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic e,
                                 output logic [31:0] r, output logic early);
        if (b == 32'd0) begin
            q = 32'd0; e = 1'b1; r = 32'd0; early = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; e = 1'b1; r = 32'd0; early = 1'b1;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            e = 1'b0; early = 1'b0;
        end
    endfunction

    // Transaction-level model: a request is accepted when idle or in the
    // ready cycle; its result appears 1 edge (early-out) or 34 edges after
    // the accepting edge and is held until the next result.
    logic        m_busy = 1'b0, m_rdy = 1'b0, m_exc = 1'b0, p_exc = 1'b0;
    logic        m_accept, p_early;
    int          m_timer = 0;
    logic [31:0] m_q = '0, m_rem = '0, p_q = '0, p_rem = '0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 1'b0; m_rdy = 1'b0; m_exc = 1'b0; m_q = '0; m_rem = '0; m_timer = 0;
        end else begin
            m_accept = start && (!m_busy || m_rdy);
            if (m_rdy) begin
                m_rdy = 1'b0;
                m_busy = 1'b0;
            end else if (m_busy) begin
                m_timer--;
                if (m_timer == 0) begin
                    m_rdy = 1'b1; m_q = p_q; m_exc = p_exc; m_rem = p_rem;
                end
            end
            if (m_accept) begin
                calc(dividend, divisor, p_q, p_exc, p_rem, p_early);
                m_busy = 1'b1;
                m_timer = p_early ? 1 : 34;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("cmp_busy", {31'd0, busy}, {31'd0, m_busy});
            check("cmp_rdy", {31'd0, result_rdy}, {31'd0, m_rdy});
            check("cmp_quotient", quotient, m_q);
            check("cmp_exception", {31'd0, exception}, {31'd0, m_exc});
`ifdef REMAINDER_OUT_EN
            check("cmp_remainder", remainder, m_rem);
`endif
        end
    end

    // Pulse start from the current negedge; operands are scrambled afterwards
    // so a design that re-reads them would be caught.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        dividend = a;
        divisor = b;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        t_start = cyc;
        dividend = $urandom;
        divisor = $urandom;
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    // Edges from the accepting edge until result_rdy is seen; -1 on timeout.
    task automatic wait_rdy(output int lat);
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (result_rdy) begin
                lat = cyc - t_start;
                break;
            end
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 9))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            4: return -32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    // Latency numbering counts the start edge as cycle 1, so a normal result
    // is visible 34 edges later (cycle 35) and an early-out 1 edge later.
    localparam int LatNorm = 34;
    localparam int LatEarly = 1;

    initial begin
        int lat;
        int rdy_seen;
        logic [31:0] tq, tr;
        logic te, tearly;

        // Pin the reference arithmetic against hand-computed values.
        calc(32'hFFFF_FFF9, 32'd2, tq, te, tr, tearly);
        check("model_neg7_div2_q", tq, 32'hFFFF_FFFD);
        check("model_neg7_div2_r", tr, 32'hFFFF_FFFF);
        calc(32'd100, 32'd7, tq, te, tr, tearly);
        check("model_100_div7_q", tq, 32'd14);
        check("model_100_div7_r", tr, 32'd2);

        #1 reset_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_quotient", quotient, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_rdy", {31'd0, result_rdy}, 32'd0);
        #2 reset_n = 1'b1;

        // 1: 7 / 2
        @(negedge clock);
        issue(32'd7, 32'd2);
        wait_rdy(lat);
        check("t1_latency", 32'(lat), 32'(LatNorm));
        check("t1_quotient", quotient, 32'd3);
        check("t1_exception", {31'd0, exception}, 32'd0);
`ifdef REMAINDER_OUT_EN
        check("t1_remainder", remainder, 32'd1);
`endif
        @(negedge clock);
        check("t1_rdy_single", {31'd0, result_rdy}, 32'd0);

        // 2: -7 / 2 and MAX / -1
        issue(32'hFFFF_FFF9, 32'd2);
        wait_rdy(lat);
        check("t2_latency", 32'(lat), 32'(LatNorm));
        check("t2_quotient", quotient, 32'hFFFF_FFFD);
`ifdef REMAINDER_OUT_EN
        check("t2_remainder", remainder, 32'hFFFF_FFFF);
`endif
        @(negedge clock);
        issue(32'h7FFF_FFFF, 32'hFFFF_FFFF);
        wait_rdy(lat);
        check("t2b_quotient", quotient, 32'h8000_0001);
        check("t2b_exception", {31'd0, exception}, 32'd0);

        // 3: divide by zero
        @(negedge clock);
        issue(32'd5, 32'd0);
        wait_rdy(lat);
        check("t3_latency", 32'(lat), 32'(LatEarly));
        check("t3_quotient", quotient, 32'd0);
        check("t3_exception", {31'd0, exception}, 32'd1);
        @(negedge clock);
        check("t3_busy_low", {31'd0, busy}, 32'd0);

        // 4: MIN / -1 overflow
        issue(32'h8000_0000, 32'hFFFF_FFFF);
        wait_rdy(lat);
        check("t4_latency", 32'(lat), 32'(LatEarly));
        check("t4_quotient", quotient, 32'h8000_0000);
        check("t4_exception", {31'd0, exception}, 32'd1);

        // 5: start while busy is ignored; start in DONE is accepted
        @(negedge clock);
        issue(32'd100, 32'd7);
        repeat (8) @(negedge clock);
        dividend = 32'd9;
        divisor = 32'd3;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_rdy(lat);
        check("t5_latency", 32'(lat), 32'(LatNorm));
        check("t5_quotient", quotient, 32'd14);
        issue(32'd9, 32'd3);
        wait_rdy(lat);
        check("t5b_latency", 32'(lat), 32'(LatNorm));
        check("t5b_quotient", quotient, 32'd3);

        // 6: asynchronous reset mid-division
        @(negedge clock);
        issue(32'd1000, 32'd3);
        repeat (19) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("t6_async_quotient", quotient, 32'd0);
        check("t6_async_busy", {31'd0, busy}, 32'd0);
        check("t6_async_rdy", {31'd0, result_rdy}, 32'd0);
        check("t6_async_exception", {31'd0, exception}, 32'd0);
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b1;
        rdy_seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (result_rdy) rdy_seen++;
        end
        check("t6_no_rdy_after_reset", 32'(rdy_seen), 32'd0);
        issue(32'd1000, 32'd3);
        wait_rdy(lat);
        check("t6_latency", 32'(lat), 32'(LatNorm));
        check("t6_quotient", quotient, 32'd333);

        // Random traffic: starts arrive at random, including while busy and
        // during the ready cycle; the model decides which are accepted.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            start = ($urandom_range(0, 3) == 0);
            dividend = pick();
            divisor = pick();
        end
        @(negedge clock);
        start = 1'b0;
        repeat (40) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
